// File: rtl/frame_uart_streamer_pkg.sv
// -----------------------------------------------------------------------------
// frame_stream_pkg
// Shared definitions for the frame UART streamer:
//   - default values for IMG_W, IMG_H, BPP, CLKS_PER_BIT and SYNC_BYTE
//   - tx_state_e : transmit (reader) FSM states
//   - frame_bytes(): packed bytes per frame for a given geometry and depth
// -----------------------------------------------------------------------------
package frame_stream_pkg;

   localparam int         DEF_IMG_W        = 240;
   localparam int         DEF_IMG_H        = 170;
   localparam int         DEF_BPP          = 1;
   localparam int         DEF_CLKS_PER_BIT = 868;
   localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SEQ,
      ST_DATA,
      ST_CSUM,
      ST_DONE
   } tx_state_e;

   // Bytes per frame; an out-of-range depth yields 0 instead of dividing by 0
   // so the top-level elaboration checks can report it.
   function automatic int frame_bytes(input int img_w, input int img_h, input int bpp);
      if (bpp < 1 || bpp > 8) return 0;
      return (img_w * img_h) / (8 / bpp);
   endfunction

endpackage

// File: rtl/frame_uart_streamer_if.sv
// -----------------------------------------------------------------------------
// frame_uart_streamer_if
// Pixel stream from the edge detector into the streamer.
//   pix_sof  : start-of-frame pulse, resynchronises capture
//   pix_de   : pixel valid (no backpressure)
//   pix_data : pixel value, the BPP MSBs are kept
// Modports: master (pixel source), slave (streamer).
// -----------------------------------------------------------------------------
interface frame_uart_streamer_if;

   logic       pix_sof;
   logic       pix_de;
   logic [7:0] pix_data;

   modport master (output pix_sof, pix_de, pix_data);
   modport slave  (input  pix_sof, pix_de, pix_data);

endinterface

// File: rtl/frame_uart_streamer_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART transmitter, LSB first, idle high.
//   clk, reset : clock, synchronous active-low reset
//   start      : accepted only while ready=1
//   data       : byte to send, captured with start
//   tx         : serial output (registered)
//   ready      : high when a new byte may be started
// ready is raised during the last clock of the stop bit, so a start issued
// then begins the next start bit exactly when the stop bit ends: characters
// are 10*CLKS_PER_BIT cycles and back-to-back with no idle time.
// -----------------------------------------------------------------------------
module uart_tx_byte
   import frame_stream_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int             CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]    shreg;     // {stop, data}; shifted out LSB first
   logic          active;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx      <= 1'b1;
         ready   <= 1'b1;
         active  <= 1'b0;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else if (ready && start) begin
         shreg   <= {1'b1, data};
         tx      <= 1'b0;
         ready   <= 1'b0;
         active  <= 1'b1;
         clk_cnt <= '0;
         bit_idx <= '0;
      end else if (active) begin
         if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end else begin
               tx      <= shreg[0];
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + 4'd1;
            end
         end else begin
            clk_cnt <= clk_cnt + CW'(1);
         end
         if (bit_idx == 4'd9 && clk_cnt == CNT_PRE_LAST) ready <= 1'b1;
      end
   end

endmodule

// File: rtl/frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// frame_uart_streamer
// Packs per-pixel edge results into bytes (BPP bits per pixel, MSB-first),
// captures complete frames into a ping-pong buffer and sends each finished
// frame over UART as: SYNC_BYTE, sequence, FRAME_BYTES data bytes
// [, XOR checksum]. Capture of frame N+1 overlaps transmission of frame N;
// a frame completed while the reader is busy is dropped.
//   clk, reset        : clock, synchronous active-low reset
//   pix (slave)       : pix_sof / pix_de / pix_data stream
//   tx                : UART out, 8N1, idle high
//   busy              : high while a frame is being transmitted
//   frame_sent        : 1-cycle pulse after the last stop bit of a frame
//   frame_drop        : 1-cycle pulse when a completed capture is discarded
// Build option: define FRAME_STREAM_CSUM_EN to append an XOR checksum of the
// data bytes after the data.
// -----------------------------------------------------------------------------
module frame_uart_streamer
   import frame_stream_pkg::*;
#(
   parameter int         IMG_W        = DEF_IMG_W,
   parameter int         IMG_H        = DEF_IMG_H,
   parameter int         BPP          = DEF_BPP,
   parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
   input  logic                  clk,
   input  logic                  reset,
   frame_uart_streamer_if.slave  pix,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_sent,
   output logic                  frame_drop
);

   localparam int PPB = (BPP >= 1 && BPP <= 8) ? 8 / BPP : 1;
   localparam int FB  = frame_bytes(IMG_W, IMG_H, BPP);
   localparam int AW  = (FB > 1) ? $clog2(FB) : 1;

   if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bad_bpp
      $error("frame_uart_streamer: BPP must be 1, 2, 4 or 8");
   end
   if ((IMG_W * IMG_H) % PPB != 0) begin : g_bad_geometry
      $error("frame_uart_streamer: IMG_W*IMG_H must be divisible by 8/BPP");
   end
   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("frame_uart_streamer: CLKS_PER_BIT must be at least 4");
   end

   // ---------------------------------------------------------------- writer
   logic [3:0]    pix_cnt, base_pix;
   logic [AW-1:0] byte_cnt, base_byte;
   logic [7:0]    pack, base_pack, pack_next;
   logic          byte_done, last_write;
   logic          wbank, rbank;
   logic          reader_free, handoff;

   tx_state_e     state;
   logic          handoff_pend;

   // pix_sof restarts the counters in the same cycle, so a pixel arriving
   // with it becomes pixel 0 of the new frame.
   // NOTE: every always_comb output gets an unconditional assignment, so no
   // path can leave a value held and infer a latch.
   always_comb begin
      base_pix   = pix.pix_sof ? '0 : pix_cnt;
      base_byte  = pix.pix_sof ? '0 : byte_cnt;
      base_pack  = pix.pix_sof ? '0 : pack;
      pack_next  = (base_pack << BPP) | (pix.pix_data >> (8 - BPP));
      byte_done  = pix.pix_de && (base_pix == 4'(PPB - 1));
      last_write = byte_done && (base_byte == AW'(FB - 1));
   end

   // The reader counts as free from DONE onward; a second hand-off while one
   // is already pending in DONE is dropped.
   assign reader_free = (state == ST_IDLE) || (state == ST_DONE && !handoff_pend);
   assign handoff     = last_write && reader_free;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pix_cnt    <= '0;
         byte_cnt   <= '0;
         pack       <= '0;
         wbank      <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         frame_drop <= 1'b0;
         if (pix.pix_de) begin
            if (byte_done) begin
               pix_cnt <= '0;
               pack    <= '0;
               if (last_write) begin
                  // Busy reader: keep wbank so the next capture overwrites it.
                  byte_cnt <= '0;
                  if (reader_free) wbank      <= ~wbank;
                  else             frame_drop <= 1'b1;
               end else begin
                  byte_cnt <= base_byte + AW'(1);
               end
            end else begin
               pix_cnt  <= base_pix + 4'd1;
               pack     <= pack_next;
               byte_cnt <= base_byte;
            end
         end else if (pix.pix_sof) begin
            pix_cnt  <= '0;
            byte_cnt <= '0;
            pack     <= '0;
         end
      end
   end

   // ------------------------------------------------------ ping-pong buffer
   // Bank index is the major (most significant) dimension.
   logic [7:0]    mem [2][FB];
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;

   // NOTE: the frame buffer has no reset; its contents are always written
   // before being read, and a reset term would prevent RAM inference.
   always_ff @(posedge clk) begin
      if (byte_done) mem[wbank][base_byte] <= pack_next;
      rd_data <= mem[rbank][rd_addr];
   end

   // ---------------------------------------------------------------- reader
   logic [7:0] seq;
   logic       uart_start, uart_ready;
   logic [7:0] uart_data;
`ifdef FRAME_STREAM_CSUM_EN
   logic [7:0] csum;
`endif

   // start is decoded from the registered state and the UART's ready so the
   // next character can begin on the very edge the previous one ends.
   always_comb begin
      uart_start = 1'b0;
      uart_data  = 8'h00;
      case (state)
         ST_SYNC: begin uart_start = uart_ready; uart_data = SYNC_BYTE; end
         ST_SEQ:  begin uart_start = uart_ready; uart_data = seq;       end
         ST_DATA: begin uart_start = uart_ready; uart_data = rd_data;   end
`ifdef FRAME_STREAM_CSUM_EN
         ST_CSUM: begin uart_start = uart_ready; uart_data = csum;      end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         frame_sent   <= 1'b0;
         seq          <= 8'h00;
         rbank        <= 1'b0;
         rd_addr      <= '0;
         handoff_pend <= 1'b0;
`ifdef FRAME_STREAM_CSUM_EN
         csum         <= 8'h00;
`endif
      end else begin
         frame_sent <= 1'b0;
         if (handoff) rbank <= wbank;
         case (state)
            ST_IDLE: if (handoff) begin
               state <= ST_SYNC;
               busy  <= 1'b1;
`ifdef FRAME_STREAM_CSUM_EN
               csum  <= 8'h00;
`endif
            end
            ST_SYNC: if (uart_ready) state <= ST_SEQ;
            // rd_addr sits at 0 during SYNC/SEQ, so byte 0 is already
            // waiting in rd_data when DATA starts.
            ST_SEQ:  if (uart_ready) state <= ST_DATA;
            ST_DATA: if (uart_ready) begin
`ifdef FRAME_STREAM_CSUM_EN
               csum <= csum ^ rd_data;
`endif
               if (rd_addr == AW'(FB - 1)) begin
                  rd_addr <= '0;
`ifdef FRAME_STREAM_CSUM_EN
                  state   <= ST_CSUM;
`else
                  state   <= ST_DONE;
`endif
               end else begin
                  rd_addr <= rd_addr + AW'(1);
               end
            end
            ST_CSUM: if (uart_ready) state <= ST_DONE;
            // ready rises in the last stop-bit cycle, so frame_sent lands on
            // the cycle right after the final stop bit ends.
            ST_DONE: begin
               if (uart_ready) begin
                  frame_sent   <= 1'b1;
                  seq          <= seq + 8'd1;
                  handoff_pend <= 1'b0;
                  if (handoff_pend || handoff) begin
                     state <= ST_SYNC;
`ifdef FRAME_STREAM_CSUM_EN
                     csum  <= 8'h00;
`endif
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (handoff) begin
                  handoff_pend <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .clk   (clk),
      .reset (reset),
      .start (uart_start),
      .data  (uart_data),
      .tx    (tx),
      .ready (uart_ready)
   );

endmodule

// File: tb/tb_frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_uart_streamer
// Directed bench for frame_uart_streamer. Two instances:
//   dut_a : IMG_W=4, IMG_H=2, BPP=1, CLKS_PER_BIT=4 (one data byte per frame)
//   dut_b : IMG_W=2, IMG_H=1, BPP=4, CLKS_PER_BIT=4 (one data byte per frame)
// A UART receiver per instance decodes tx into a byte log; frame_sent and
// frame_drop pulses are counted. Expected bytes are hand-computed.
// -----------------------------------------------------------------------------
module tb_frame_uart_streamer;

   localparam int CPB = 4;
   localparam int RXD = 2048;
`ifdef FRAME_STREAM_CSUM_EN
   localparam int CHARS = 4;
`else
   localparam int CHARS = 3;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic tx_a, busy_a, sent_a_p, drop_a_p;
   logic tx_b, busy_b, sent_b_p, drop_b_p;

   frame_uart_streamer_if pa ();
   frame_uart_streamer_if pb ();

   frame_uart_streamer #(
      .IMG_W(4), .IMG_H(2), .BPP(1), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
   ) dut_a (
      .clk(clk), .reset(rst_a), .pix(pa.slave),
      .tx(tx_a), .busy(busy_a), .frame_sent(sent_a_p), .frame_drop(drop_a_p)
   );

   frame_uart_streamer #(
      .IMG_W(2), .IMG_H(1), .BPP(4), .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
   ) dut_b (
      .clk(clk), .reset(rst_b), .pix(pb.slave),
      .tx(tx_b), .busy(busy_b), .frame_sent(sent_b_p), .frame_drop(drop_b_p)
   );

   // ------------------------------------------------------------ checking
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // --------------------------------------------------- pulse counters
   int sent_a = 0, drop_a = 0, sent_b = 0, drop_b = 0;
   always @(negedge clk) begin
      if (sent_a_p === 1'b1) sent_a++;
      if (drop_a_p === 1'b1) drop_a++;
      if (sent_b_p === 1'b1) sent_b++;
      if (drop_b_p === 1'b1) drop_b++;
   end

   // ------------------------------------------------------ UART receivers
   logic [7:0] rx_a [RXD];
   logic [7:0] rx_b [RXD];
   int rx_a_wr = 0, rx_b_wr = 0, rx_a_rd = 0, rx_b_rd = 0;
   int bad_stop_a = 0, bad_stop_b = 0;

   // Entered on the first falling clk edge inside a start bit; samples each
   // following bit near its middle.
   task automatic rx_char(input bit which, output logic [7:0] b, output logic stop_bit);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = which ? tx_b : tx_a;
      end
      repeat (CPB) @(negedge clk);
      stop_bit = which ? tx_b : tx_a;
   endtask

   initial begin : mon_a
      logic [7:0] b;
      logic       sb;
      forever begin
         @(negedge clk);
         if (rst_a === 1'b1 && tx_a === 1'b0) begin
            rx_char(1'b0, b, sb);
            rx_a[rx_a_wr % RXD] = b;
            rx_a_wr++;
            if (sb !== 1'b1) bad_stop_a++;
         end
      end
   end

   initial begin : mon_b
      logic [7:0] b;
      logic       sb;
      forever begin
         @(negedge clk);
         if (rst_b === 1'b1 && tx_b === 1'b0) begin
            rx_char(1'b1, b, sb);
            rx_b[rx_b_wr % RXD] = b;
            rx_b_wr++;
            if (sb !== 1'b1) bad_stop_b++;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic pix(input bit which, input logic sof, input logic [7:0] d);
      if (which) begin pb.pix_sof = sof; pb.pix_de = 1'b1; pb.pix_data = d; end
      else       begin pa.pix_sof = sof; pa.pix_de = 1'b1; pa.pix_data = d; end
      @(posedge clk); #1;
      if (which) begin pb.pix_sof = 1'b0; pb.pix_de = 1'b0; end
      else       begin pa.pix_sof = 1'b0; pa.pix_de = 1'b0; end
   endtask

   // One dut_a frame: pixel i carries bits[7-i] in its MSB; LSBs are junk.
   task automatic feed_frame_a(input logic [7:0] bits);
      for (int i = 0; i < 8; i++) pix(1'b0, i == 0, {bits[7-i], 7'h2B});
   endtask

   task automatic do_reset(input bit which);
      @(posedge clk); #1;
      if (which) rst_b = 1'b0; else rst_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (which) rst_b = 1'b1; else rst_a = 1'b1;
   endtask

   task automatic wait_sent(input bit which, input int target, input string tag);
      int n;
      n = 0;
      while (((which ? sent_b : sent_a) < target) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, " frame_sent seen"}, 32'((which ? sent_b : sent_a) >= target), 32'd1);
   endtask

   task automatic expect_frame(input bit which, input logic [7:0] seq,
                               input logic [7:0] data, input string tag);
      int         avail;
      logic [7:0] got [4];
      avail = which ? (rx_b_wr - rx_b_rd) : (rx_a_wr - rx_a_rd);
      check({tag, " char count"}, avail, CHARS);
      if (avail >= CHARS) begin
         for (int k = 0; k < CHARS; k++) begin
            if (which) begin got[k] = rx_b[rx_b_rd % RXD]; rx_b_rd++; end
            else       begin got[k] = rx_a[rx_a_rd % RXD]; rx_a_rd++; end
         end
         check({tag, " sync"}, 32'(got[0]), 32'h0000_00A5);
         check({tag, " seq"},  32'(got[1]), 32'(seq));
         check({tag, " data"}, 32'(got[2]), 32'(data));
`ifdef FRAME_STREAM_CSUM_EN
         check({tag, " csum"}, 32'(got[3]), 32'(data));
`endif
      end
      if (which) rx_b_rd = rx_b_wr; else rx_a_rd = rx_a_wr;
   endtask

   initial begin : watchdog
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int         anomalies;
      int         base_s, base_d;
      logic [7:0] iv;

      pa.pix_sof = 1'b0; pa.pix_de = 1'b0; pa.pix_data = 8'h00;
      pb.pix_sof = 1'b0; pb.pix_de = 1'b0; pb.pix_data = 8'h00;

      // ---- reset: held low for several edges, outputs idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset tx_a",   32'(tx_a),   32'd1);
      check("reset busy_a", 32'(busy_a), 32'd0);
      check("reset tx_b",   32'(tx_b),   32'd1);
      @(posedge clk); #1;
      rst_a = 1'b1;
      rst_b = 1'b1;

      anomalies = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || sent_a_p !== 1'b0 || drop_a_p !== 1'b0 ||
             tx_b !== 1'b1 || busy_b !== 1'b0 || sent_b_p !== 1'b0 || drop_b_p !== 1'b0)
            anomalies++;
      end
      check("quiet after reset", anomalies, 0);
      check("no chars after reset", rx_a_wr + rx_b_wr, 0);

      // ---- pack and send: MSBs 1,0,1,1,0,0,1,0 -> 0xB2
      feed_frame_a(8'hB2);
      @(negedge clk);
      check("busy after hand-off", 32'(busy_a), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("start bit within 2 cycles", 32'(tx_a), 32'd0);
      wait_sent(1'b0, 1, "pack");
      expect_frame(1'b0, 8'h00, 8'hB2, "pack");
      repeat (50) @(negedge clk);
      check("pack frame_sent count", sent_a, 1);
      check("pack no drop", drop_a, 0);
      check("pack busy cleared", 32'(busy_a), 32'd0);

      // ---- depth: BPP=4, 0xC3 then 0x5F -> 0xC5
      pix(1'b1, 1'b1, 8'hC3);
      pix(1'b1, 1'b0, 8'h5F);
      wait_sent(1'b1, 1, "depth");
      expect_frame(1'b1, 8'h00, 8'hC5, "depth");

      // ---- overlap and drop: frame 2 completes while frame 1 is on the wire
      do_reset(1'b0);
      rx_a_rd = rx_a_wr;
      base_s  = sent_a;
      base_d  = drop_a;
      feed_frame_a(8'hFF);
      feed_frame_a(8'h00);
      @(negedge clk);
      check("drop pulse after last write", 32'(drop_a_p), 32'd1);
      check("busy during drop", 32'(busy_a), 32'd1);
      wait_sent(1'b0, base_s + 1, "ovl f1");
      expect_frame(1'b0, 8'h00, 8'hFF, "ovl f1");
      check("drop count", drop_a - base_d, 1);
      feed_frame_a(8'h55);
      wait_sent(1'b0, base_s + 2, "ovl f3");
      expect_frame(1'b0, 8'h01, 8'h55, "ovl f3");

      // ---- resync: 3 stale zero pixels, then sof + 8 x 0xFF
      pix(1'b0, 1'b1, 8'h00);
      pix(1'b0, 1'b0, 8'h00);
      pix(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) pix(1'b0, i == 0, 8'hFF);
      wait_sent(1'b0, base_s + 3, "resync");
      expect_frame(1'b0, 8'h02, 8'hFF, "resync");
      check("resync drop count", drop_a - base_d, 1);
      check("resync frame_sent count", sent_a - base_s, 3);

      // ---- sequence wrap on dut_b: 257 frames, data byte varies per frame
      do_reset(1'b1);
      rx_b_rd = rx_b_wr;
      base_s  = sent_b;
      base_d  = drop_b;
      for (int i = 0; i < 257; i++) begin
         iv = 8'(i);
         pix(1'b1, 1'b1, {iv[3:0], 4'hA});
         pix(1'b1, 1'b0, {iv[7:4], 4'h5});
         wait_sent(1'b1, base_s + i + 1, "wrap");
         expect_frame(1'b1, iv, {iv[3:0], iv[7:4]}, "wrap");
      end
      repeat (20) @(negedge clk);
      check("wrap frame_sent count", sent_b - base_s, 257);
      check("wrap no drop", drop_b - base_d, 0);
      check("stop bits a", bad_stop_a, 0);
      check("stop bits b", bad_stop_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frame_uart_streamer.md
# frame_uart_streamer

Parametrised successor to the edge-frame UART path. Packs a stream of per-pixel edge results into bytes at a configurable bit depth, stores complete frames in a ping-pong frame buffer, and transmits each completed frame over UART with a sync/sequence header. It sits between the Canny output and the host-facing TX pin. Capture of frame N+1 overlaps with transmission of frame N.

## Interface
Parameters:
- IMG_W, 240: pixels per line.
- IMG_H, 170: lines per frame.
- BPP, 1: bits kept per pixel; legal values are 1, 2, 4, 8.
- CLKS_PER_BIT, 868: UART bit period in clk cycles, minimum 4.
- SYNC_BYTE, 8'hA5: first header byte.

Ports:
- clk, in, 1: system clock; everything is on the rising edge.
- reset, in, 1: synchronous, active-low reset.
- pix_sof, in, 1: start-of-frame pulse; resynchronises the capture counters.
- pix_de, in, 1: pixel valid.
- pix_data, in, 8: pixel value; the BPP MSBs are kept.
- tx, out, 1: UART serial out; 8N1, LSB first, idle high.
- busy, out, 1: high while a frame is being transmitted.
- frame_sent, out, 1: one-cycle pulse after the last stop bit of a frame.
- frame_drop, out, 1: one-cycle pulse when a completed capture is discarded.

## Operation
Derived constants:
- PPB = 8/BPP.
- FRAME_BYTES = IMG_W*IMG_H/PPB. IMG_W*IMG_H must be divisible by PPB; an elaboration error fires otherwise.

Capture (writer):
- Each pix_de shifts pix_data[7:8-BPP] into the pack register, MSB-first. The first pixel lands in bits [7:8-BPP].
- After PPB pixels, one byte is written to wbank at address byte_cnt, and byte_cnt increments.
- pix_sof clears the pack and byte counters and discards any partial byte. If pix_de is high in the same cycle as pix_sof, that pixel is pixel 0 of the new frame.
- When byte FRAME_BYTES-1 is written, the frame is complete:
  - Reader idle: hand wbank to the reader, toggle wbank, restart capture.
  - Reader busy: pulse frame_drop, keep wbank, and restart capture so the same bank is overwritten.

Transmit (reader) FSM, states IDLE → SYNC → SEQ → DATA → [CSUM] → DONE → IDLE:
- IDLE: wait for a hand-off.
- SYNC: send SYNC_BYTE.
- SEQ: send an 8-bit frame sequence number. It starts at 0 after reset, increments on each frame_sent, and wraps 255→0.
- DATA: send rbank bytes in address order 0..FRAME_BYTES-1.
- CSUM: present only with the configuration macro; see Configuration.
- DONE: pulse frame_sent and return to IDLE.
- busy is high in every state except IDLE.

Boundary rules:
- A hand-off and a frame_sent in the same cycle is not a drop. The reader is considered idle from DONE onward.
- Dropped frames do not advance the sequence number, so the host detects drops as gaps only through timing, not through sequence numbers.
- Reset mid-frame aborts both the writer and the reader. tx is high on the cycle after reset is sampled low, and the partial UART character is truncated.

## Timing
- Reset values:
  - Outputs: tx=1, busy=0, frame_sent=0, frame_drop=0.
  - Internal state: sequence=0, wbank=0, all counters 0.
- The RAM is synchronous with 1-cycle read latency. The reader issues the address one cycle before the byte is needed, so consecutive UART characters are back-to-back with no idle bits.
- A character is 10*CLKS_PER_BIT cycles: start bit, 8 data bits, stop bit.
- busy rises the cycle after the hand-off. The start bit of SYNC begins within 2 cycles of the hand-off.
- Frame length on the wire is (FRAME_BYTES+2) characters, or +3 with the checksum enabled.
- frame_sent is asserted the cycle after the final stop bit ends.
- frame_drop is asserted the cycle after the final byte write of the discarded capture.
- No input backpressure: pix_de is accepted every cycle.

## Configuration
- FRAME_STREAM_CSUM_EN defined:
  - The CSUM state sends an 8-bit XOR of all DATA bytes of the frame. The header is not included.
  - The accumulator clears on entering SYNC.
- Undefined: the CSUM state and the accumulator are absent, and DATA goes directly to DONE.

## Structure
- Package frame_stream_pkg holds:
  - the reader state enum (tx_state_e);
  - the default constants for IMG_W, IMG_H, BPP, CLKS_PER_BIT and SYNC_BYTE;
  - a function computing FRAME_BYTES.
- Sub-module uart_tx_byte:
  - Inputs: clk, reset, start, data[7:0].
  - Outputs: tx, ready.
  - Parameter: CLKS_PER_BIT.
  - Handshake: start is accepted only while ready=1. ready drops the next cycle and rises again at the end of the stop bit.
- The ping-pong RAM is inferred in the top module as one array of depth 2*FRAME_BYTES, with the bank index as the address MSB.

## Test plan
- Reset check, with IMG_W=4, IMG_H=2, BPP=1, CLKS_PER_BIT=4: hold reset low for 3 cycles → tx=1, busy=0, and no pulses for 100 cycles after release.
- Pack and send, same parameters: 8 pixels with MSBs 1,0,1,1,0,0,1,0 → the wire carries A5, 00, B2, and frame_sent pulses once. With the checksum enabled, a trailing B2 is also sent.
- Depth: BPP=4, IMG_W=2, IMG_H=1, pixels 0xC3 then 0x5F → data byte 0xC5.
- Overlap and drop: feed frame 2 completely while frame 1 is still transmitting → frame_drop pulses once. Frame 3, fed after frame_sent, goes out with sequence 01.
- Resync: pix_sof after 3 pixels of a frame, then 8 pixels 0xFF → data byte 0xFF, with the stale partial byte discarded.
- Sequence wrap: 257 frames → sequence bytes run 00..FF, then 00, and frame_sent count = 257.
